// File: rtl/prco_sequencer.sv
// prco_sequencer: central pipeline sequencer for the prco core.
//
// A single state machine steps each instruction through the pipeline:
// FETCH, DECODE, REGRD, EXEC, RES, optionally MEM, then WB. It owns the
// program counter and arbitrates the single lmem port between instruction
// fetch (address = PC) and load/store (address = captured ALU result).
// It also supports debug single-stepping (HOLD state) and UART back-pressure
// (WB stretches while the TX FIFO is full).
//
// Parameters:
//   MEM_LAT  - lmem read latency in cycles (1..4)
//   RESET_PC - program counter value after reset
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_en, i_mode, i_step      run enable, debug mode, step request
//   i_dec_*                   decoded instruction attributes
//   i_alu_branch/result       branch-taken flag, target / effective address
//   i_uart_full               UART TX FIFO full
//   q_pc, q_mem_addr, q_mem_we            PC and lmem port
//   q_ce_dec/reg/alu                      stage enables (one-cycle pulses)
//   q_reg_we, q_reg_src_mem               register write-back control
//   q_uart_transmit, q_instr_done         retire-time strobes
//   q_state                               current state, for debug
module prco_sequencer #(
    parameter int          MEM_LAT  = 1,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_en,
    input  logic        i_mode,
    input  logic        i_step,
    input  logic        i_dec_req_ram,
    input  logic        i_dec_ram_we,
    input  logic        i_dec_reg_we,
    input  logic        i_dec_uart_tx,
    input  logic        i_alu_branch,
    input  logic [15:0] i_alu_result,
    input  logic        i_uart_full,
    output logic [15:0] q_pc,
    output logic [15:0] q_mem_addr,
    output logic        q_mem_we,
    output logic        q_ce_dec,
    output logic        q_ce_reg,
    output logic        q_ce_alu,
    output logic        q_reg_we,
    output logic        q_reg_src_mem,
    output logic        q_uart_transmit,
    output logic        q_instr_done,
    output logic [3:0]  q_state
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_REGRD  = 4'd3;
    localparam logic [3:0] ST_EXEC   = 4'd4;
    localparam logic [3:0] ST_RES    = 4'd5;
    localparam logic [3:0] ST_MEM    = 4'd6;
    localparam logic [3:0] ST_WB     = 4'd7;
    localparam logic [3:0] ST_HOLD   = 4'd8;

    // Last count value of a MEM_LAT-cycle wait in FETCH or MEM.
    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    logic [3:0]  state_r;
    logic [3:0]  state_next_s;
    logic [1:0]  lat_cnt_r;
    logic [1:0]  lat_cnt_next_s;
    logic        lat_done_s;
    logic [15:0] pc_r;
    logic [15:0] pc_next_s;
    logic [15:0] res_r;
    logic        br_r;
    logic [15:0] mem_addr_r;
    logic [15:0] mem_addr_next_s;
    logic        flag_req_ram_r;
    logic        flag_ram_we_r;
    logic        flag_reg_we_r;
    logic        flag_uart_tx_r;
    logic        step_d_r;
    logic        step_rise_s;
    logic        stall_s;
    logic        wb_exit_s;
    logic        ce_dec_r;
    logic        ce_reg_r;
    logic        ce_alu_r;
    logic        mem_we_r;
    logic        reg_src_mem_r;

    assign lat_done_s  = (lat_cnt_r == LAT_LAST);
    assign step_rise_s = i_step & ~step_d_r;
    // WB stretches while a UART push is pending against a full FIFO.
    assign stall_s     = (state_r == ST_WB) & flag_uart_tx_r & i_uart_full;
    assign wb_exit_s   = (state_r == ST_WB) & ~stall_s;

    // Next-state decode of the sequencer FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:   state_next_s = i_en ? ST_FETCH : ST_IDLE;
            ST_FETCH:  state_next_s = lat_done_s ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_next_s = ST_REGRD;
            ST_REGRD:  state_next_s = ST_EXEC;
            ST_EXEC:   state_next_s = ST_RES;
            ST_RES:    state_next_s = flag_req_ram_r ? ST_MEM : ST_WB;
            ST_MEM:    state_next_s = lat_done_s ? ST_WB : ST_MEM;
            ST_WB: begin
                if (stall_s) begin
                    state_next_s = ST_WB;
                end else if (i_mode) begin
                    state_next_s = ST_HOLD;
                end else if (i_en) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Dropping i_en wins over a simultaneous step or mode change.
                if (!i_en) begin
                    state_next_s = ST_IDLE;
                end else if (step_rise_s || !i_mode) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Latency counter for the FETCH and MEM waits; zero on entry to either.
    always_comb begin
        lat_cnt_next_s = 2'd0;
        if ((state_r == ST_FETCH || state_r == ST_MEM) && !lat_done_s) begin
            lat_cnt_next_s = lat_cnt_r + 2'd1;
        end else begin
            lat_cnt_next_s = 2'd0;
        end
    end

    // PC and lmem address for the next cycle.
    always_comb begin
        pc_next_s       = pc_r;
        mem_addr_next_s = pc_r;
        if (wb_exit_s) begin
            pc_next_s = br_r ? res_r : (pc_r + 16'd1);
        end else begin
            pc_next_s = pc_r;
        end
        // Entering MEM from RES uses the ALU result being captured this edge.
        if (state_next_s == ST_MEM) begin
            mem_addr_next_s = (state_r == ST_RES) ? i_alu_result : res_r;
        end else begin
            mem_addr_next_s = pc_next_s;
        end
    end

    // State, datapath captures and registered strobes.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r        <= ST_IDLE;
            lat_cnt_r      <= 2'd0;
            pc_r           <= RESET_PC;
            mem_addr_r     <= RESET_PC;
            res_r          <= 16'h0000;
            br_r           <= 1'b0;
            flag_req_ram_r <= 1'b0;
            flag_ram_we_r  <= 1'b0;
            flag_reg_we_r  <= 1'b0;
            flag_uart_tx_r <= 1'b0;
            step_d_r       <= 1'b0;
            ce_dec_r       <= 1'b0;
            ce_reg_r       <= 1'b0;
            ce_alu_r       <= 1'b0;
            mem_we_r       <= 1'b0;
            reg_src_mem_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            lat_cnt_r  <= lat_cnt_next_s;
            pc_r       <= pc_next_s;
            mem_addr_r <= mem_addr_next_s;
            step_d_r   <= i_step;
            if (state_r == ST_REGRD) begin
                flag_req_ram_r <= i_dec_req_ram;
                flag_ram_we_r  <= i_dec_ram_we;
                flag_reg_we_r  <= i_dec_reg_we;
                flag_uart_tx_r <= i_dec_uart_tx;
            end
            if (state_r == ST_RES) begin
                res_r <= i_alu_result;
                br_r  <= i_alu_branch;
            end
            ce_dec_r      <= (state_next_s == ST_DECODE);
            ce_reg_r      <= (state_next_s == ST_REGRD);
            ce_alu_r      <= (state_next_s == ST_EXEC);
            // MEM is only entered from RES, so this marks its first cycle.
            mem_we_r      <= (state_r == ST_RES) & flag_req_ram_r & flag_ram_we_r;
            reg_src_mem_r <= (state_next_s == ST_WB) & flag_req_ram_r & ~flag_ram_we_r;
        end
    end

    assign q_pc            = pc_r;
    assign q_mem_addr      = mem_addr_r;
    assign q_mem_we        = mem_we_r;
    assign q_ce_dec        = ce_dec_r;
    assign q_ce_reg        = ce_reg_r;
    assign q_ce_alu        = ce_alu_r;
    assign q_reg_src_mem   = reg_src_mem_r;
    assign q_state         = state_r;
    // Retire strobes follow the live FIFO-full input so a stalled WB shows none.
    assign q_reg_we        = wb_exit_s & flag_reg_we_r;
    assign q_uart_transmit = wb_exit_s & flag_uart_tx_r;
    assign q_instr_done    = wb_exit_s;

endmodule

// File: tb/tb_prco_sequencer.sv
// Scoreboard bench for prco_sequencer: expectations for each retired
// instruction are queued by the stimulus; a monitor pops one per q_instr_done.
module tb_prco_sequencer;

    logic clk = 1'b0;
    logic rst_n, rst2_n, en, mode, step;
    logic req_ram, ram_we, dreg_we, duart, branch, full;
    logic [15:0] result;

    logic [15:0] pc, mem_addr, pc2, mem_addr2;
    logic mem_we, ce_dec, ce_reg, ce_alu, reg_we, src_mem, utx, done;
    logic mem_we2, ce_dec2, ce_reg2, ce_alu2, reg_we2, src_mem2, utx2, done2;
    logic [3:0] state, state2;

    typedef struct {
        logic        reg_we;
        logic        src_mem;
        logic        uart;
        logic [15:0] next_pc;
        int          len;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    bit stim_done = 1'b0;

    // monitor state
    int mon_cyc = 0;
    int fetch_cyc = 0;
    logic [3:0] prev_state = 4'd0;
    bit pend = 1'b0;
    logic [15:0] pend_pc;

    prco_sequencer #(.MEM_LAT(1), .RESET_PC(16'h0000)) u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_mode(mode), .i_step(step),
        .i_dec_req_ram(req_ram), .i_dec_ram_we(ram_we), .i_dec_reg_we(dreg_we),
        .i_dec_uart_tx(duart), .i_alu_branch(branch), .i_alu_result(result),
        .i_uart_full(full), .q_pc(pc), .q_mem_addr(mem_addr), .q_mem_we(mem_we),
        .q_ce_dec(ce_dec), .q_ce_reg(ce_reg), .q_ce_alu(ce_alu), .q_reg_we(reg_we),
        .q_reg_src_mem(src_mem), .q_uart_transmit(utx), .q_instr_done(done),
        .q_state(state)
    );

    prco_sequencer #(.MEM_LAT(2), .RESET_PC(16'h0000)) u_dut2 (
        .i_clk(clk), .i_reset_n(rst2_n), .i_en(en), .i_mode(mode), .i_step(step),
        .i_dec_req_ram(req_ram), .i_dec_ram_we(ram_we), .i_dec_reg_we(dreg_we),
        .i_dec_uart_tx(duart), .i_alu_branch(branch), .i_alu_result(result),
        .i_uart_full(full), .q_pc(pc2), .q_mem_addr(mem_addr2), .q_mem_we(mem_we2),
        .q_ce_dec(ce_dec2), .q_ce_reg(ce_reg2), .q_ce_alu(ce_alu2), .q_reg_we(reg_we2),
        .q_reg_src_mem(src_mem2), .q_uart_transmit(utx2), .q_instr_done(done2),
        .q_state(state2)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_instr(input logic rq, input logic we, input logic rwe,
                             input logic ut, input logic br, input logic [15:0] res);
        req_ram = rq; ram_we = we; dreg_we = rwe; duart = ut; branch = br; result = res;
    endtask

    task automatic push(input logic rwe, input logic src, input logic ut,
                        input logic [15:0] npc, input int len);
        exp_t e;
        e.reg_we = rwe; e.src_mem = src; e.uart = ut; e.next_pc = npc; e.len = len;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s: no q_instr_done within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_state(input string name, input logic [3:0] st, input int budget);
        int n = 0;
        while (state !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (state !== st) begin
            tests++;
            fails++;
            $display("FAIL %s: state %0d not reached, at %0d", name, st, state);
        end
    endtask

    initial begin
        fork
            // ---------------- monitor ----------------
            begin
                while (!stim_done) begin
                    @(negedge clk);
                    mon_cyc++;
                    if (pend) begin
                        chk("sb_next_pc", {16'h0, pc}, {16'h0, pend_pc});
                        chk("sb_fetch_addr", {16'h0, mem_addr}, {16'h0, pend_pc});
                        pend = 1'b0;
                    end
                    if (state == 4'd1 && prev_state != 4'd1) fetch_cyc = mon_cyc;
                    prev_state = state;
                    if (done) begin
                        tests++;
                        if (sb.size() == 0) begin
                            fails++;
                            $display("FAIL sb_unexpected_done: got done at pc %0h expected none", pc);
                        end else begin
                            exp_t e;
                            e = sb.pop_front();
                            chk("sb_reg_we", {31'h0, reg_we}, {31'h0, e.reg_we});
                            chk("sb_src_mem", {31'h0, src_mem}, {31'h0, e.src_mem});
                            chk("sb_uart", {31'h0, utx}, {31'h0, e.uart});
                            chk("sb_len", 32'(mon_cyc - fetch_cyc + 1), 32'(e.len));
                            pend = 1'b1;
                            pend_pc = e.next_pc;
                        end
                    end
                end
            end
            // ---------------- stimulus ----------------
            begin
                logic [5:0] v_dec, v_reg, v_alu, v_rwe, v_done;
                int we_cnt, wb, tx, bad, dcnt, first, len2;
                logic [15:0] we_addr;
                logic src2;

                rst_n = 1'b0; rst2_n = 1'b0; en = 1'b0; mode = 1'b0; step = 1'b0; full = 1'b0;
                set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005);
                repeat (2) @(negedge clk);
                chk("rst_state", {28'h0, state}, 32'h0);
                chk("rst_pc", {16'h0, pc}, 32'h0);
                chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
                chk("rst_strobes", {23'h0, mem_we, ce_dec, ce_reg, ce_alu, reg_we,
                                    src_mem, utx, done, 1'b0}, 32'h0);

                // branch 0 -> 5
                push(1'b0, 1'b0, 1'b0, 16'h0005, 6);
                en = 1'b1; rst_n = 1'b1;
                @(negedge clk);
                chk("first_fetch", {28'h0, state}, 32'h1);
                wait_done("br5", 20);

                // ALU add at PC 5: stage pulse timing
                set_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
                push(1'b1, 1'b0, 1'b0, 16'h0006, 6);
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    if (c == 0) chk("add_fetch_addr", {16'h0, mem_addr}, 32'h5);
                    v_dec[c] = ce_dec; v_reg[c] = ce_reg; v_alu[c] = ce_alu;
                    v_rwe[c] = reg_we; v_done[c] = done;
                end
                chk("add_ce_dec", {26'h0, v_dec}, 32'b000010);
                chk("add_ce_reg", {26'h0, v_reg}, 32'b000100);
                chk("add_ce_alu", {26'h0, v_alu}, 32'b001000);
                chk("add_reg_we", {26'h0, v_rwe}, 32'b100000);
                chk("add_done", {26'h0, v_done}, 32'b100000);

                // store to 0x0040 at PC 6
                set_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040);
                push(1'b0, 1'b0, 1'b0, 16'h0007, 7);
                we_cnt = 0; we_addr = 16'h0;
                for (int c = 0; c < 7; c++) begin
                    @(negedge clk);
                    if (mem_we) begin
                        we_cnt++;
                        we_addr = mem_addr;
                    end
                end
                chk("st_we_cnt", 32'(we_cnt), 32'd1);
                chk("st_we_addr", {16'h0, we_addr}, 32'h40);
                chk("st_done_c6", {31'h0, done}, 32'h1);

                // load at PC 7
                set_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0050);
                push(1'b1, 1'b1, 1'b0, 16'h0008, 7);
                wait_done("ld", 20);

                // branch to 0x0100, then to 0xFFFF, then wrap
                set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100);
                push(1'b0, 1'b0, 1'b0, 16'h0100, 6);
                wait_done("br100", 20);
                set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
                push(1'b0, 1'b0, 1'b0, 16'hFFFF, 6);
                wait_done("brffff", 20);
                set_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0003);
                push(1'b1, 1'b0, 1'b0, 16'h0000, 6);
                wait_done("wrap", 20);

                // UART push with FIFO full for the first 3 WB cycles
                set_instr(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0007);
                push(1'b1, 1'b0, 1'b1, 16'h0001, 9);
                full = 1'b1;
                wb = 0; tx = 0; dcnt = 0;
                for (int c = 0; c < 20 && dcnt == 0; c++) begin
                    @(negedge clk);
                    if (state == 4'd7) wb++;
                    if (utx) tx++;
                    if (done) dcnt++;
                    if (wb == 3 && full) begin
                        @(posedge clk);
                        #1 full = 1'b0;
                    end
                end
                full = 1'b0;
                chk("uart_wb_cycles", 32'(wb), 32'd4);
                chk("uart_tx_pulses", 32'(tx), 32'd1);
                chk("uart_done", 32'(dcnt), 32'd1);

                // i_en cleared in EXEC: retires, then IDLE
                set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
                push(1'b0, 1'b0, 1'b0, 16'h0002, 6);
                wait_state("en_exec", 4'd4, 10);
                en = 1'b0;
                wait_done("en_off", 20);
                @(negedge clk);
                chk("en_off_idle", {28'h0, state}, 32'h0);

                // debug single-step
                mode = 1'b1; en = 1'b1;
                push(1'b0, 1'b0, 1'b0, 16'h0003, 6);
                wait_done("dbg0", 20);
                bad = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (state != 4'd8) bad++;
                end
                chk("dbg_hold", 32'(bad), 32'd0);
                push(1'b0, 1'b0, 1'b0, 16'h0004, 6);
                step = 1'b1;
                @(negedge clk);
                step = 1'b0;
                wait_done("dbg_step", 20);
                repeat (3) @(negedge clk);
                chk("dbg_hold2", {28'h0, state}, 32'h8);
                push(1'b0, 1'b0, 1'b0, 16'h0005, 6);
                step = 1'b1;
                dcnt = 0;
                repeat (25) begin
                    @(negedge clk);
                    if (done) dcnt++;
                end
                step = 1'b0;
                chk("dbg_held_step", 32'(dcnt), 32'd1);

                // reset in DECODE
                mode = 1'b0;
                wait_state("to_decode", 4'd2, 10);
                rst_n = 1'b0;
                #1;
                chk("rstdec_state", {28'h0, state}, 32'h0);
                chk("rstdec_pc", {16'h0, pc}, 32'h0);
                chk("rstdec_ce_dec", {31'h0, ce_dec}, 32'h0);

                // release, restart at RESET_PC, then reset in MEM of a store
                @(negedge clk);
                set_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0040);
                rst_n = 1'b1;
                @(negedge clk);
                chk("restart_fetch", {28'h0, state}, 32'h1);
                chk("restart_addr", {16'h0, mem_addr}, 32'h0);
                wait_state("to_mem", 4'd6, 10);
                chk("mem_we_before", {31'h0, mem_we}, 32'h1);
                rst_n = 1'b0;
                #1;
                chk("rstmem_we", {31'h0, mem_we}, 32'h0);
                chk("rstmem_addr", {16'h0, mem_addr}, 32'h0);
                chk("rstmem_wb", {30'h0, reg_we, done}, 32'h0);

                // MEM_LAT=2 load on the second instance
                set_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0022);
                @(negedge clk);
                rst2_n = 1'b1;
                first = -1; len2 = 0; src2 = 1'b0;
                for (int n = 0; n < 30 && len2 == 0; n++) begin
                    @(negedge clk);
                    if (state2 == 4'd1 && first < 0) first = n;
                    if (done2) begin
                        len2 = n - first + 1;
                        src2 = src_mem2;
                    end
                end
                chk("lat2_len", 32'(len2), 32'd9);
                chk("lat2_src_mem", {31'h0, src2}, 32'h1);
                @(negedge clk);
                chk("lat2_pc", {16'h0, pc2}, 32'h1);
                stim_done = 1'b1;
            end
        join
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prco_sequencer.md
# prco_sequencer

Central pipeline sequencer for the prco core. It replaces the chained chip-enable pulses between fetch, decode, register file, ALU, local memory and UART with one explicit state machine. It owns the program counter and drives the local-memory address and write-enable mux. It also arbitrates the single lmem port between instruction fetch and load/store, and implements debug single-stepping and UART back-pressure stalls.

## Interface
- MEM_LAT, 1: lmem read latency in cycles (1..4), from address valid to data valid.
- RESET_PC, 16'h0000: PC value loaded on reset.

Clock and reset are one clock; reset is asynchronous and active-low.

- i_clk  in  1  core clock; all state changes on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_en  in  1  run enable; sampled only at instruction boundaries.
- i_mode  in  1  0 = free-run, 1 = debug single-step.
- i_step  in  1  step request; rising edge detected internally.
- i_dec_req_ram  in  1  decoded instruction accesses lmem.
- i_dec_ram_we  in  1  access is a store (qualified by i_dec_req_ram).
- i_dec_reg_we  in  1  instruction writes the register file.
- i_dec_uart_tx  in  1  instruction pushes a byte to the UART.
- i_alu_branch  in  1  ALU branch-taken flag.
- i_alu_result  in  16  ALU result: branch target or effective address.
- i_uart_full  in  1  UART TX FIFO full.
- q_pc  out  16  program counter.
- q_mem_addr  out  16  lmem address.
- q_mem_we  out  1  lmem write strobe.
- q_ce_dec  out  1  decoder enable.
- q_ce_reg  out  1  register-read enable.
- q_ce_alu  out  1  ALU enable.
- q_reg_we  out  1  register write-back strobe.
- q_reg_src_mem  out  1  write-back source: 1 = lmem data, 0 = ALU.
- q_uart_transmit  out  1  UART push strobe.
- q_instr_done  out  1  one-cycle pulse per retired instruction.
- q_state  out  4  current state encoding, for debug.

## Operation
States and encodings: IDLE=0, FETCH=1, DECODE=2, REGRD=3, EXEC=4, RES=5, MEM=6, WB=7, HOLD=8.

Transitions:
- IDLE -> FETCH when i_en=1.
- FETCH: q_mem_addr=q_pc. Holds MEM_LAT cycles, counted by a latency counter, then -> DECODE.
- DECODE: q_ce_dec=1 for this one cycle, then -> REGRD.
- REGRD: q_ce_reg=1. Latches i_dec_req_ram, i_dec_ram_we, i_dec_reg_we and i_dec_uart_tx into instruction flags. Then -> EXEC.
- EXEC: q_ce_alu=1, then -> RES.
- RES: captures i_alu_result into r_res and i_alu_branch into r_br. Goes -> MEM if the latched req_ram flag is set, else -> WB.
- MEM: q_mem_addr=r_res. q_mem_we=1 in the first MEM cycle only, and only if the latched we flag is set. Holds MEM_LAT cycles, then -> WB.
- WB: q_reg_we = latched reg_we; q_reg_src_mem=1 for a load (req_ram & !ram_we).
  - If uart_tx is latched and i_uart_full=1: stay in WB and deassert q_reg_we and q_uart_transmit until the FIFO is not full.
  - Otherwise, on exit: pulse q_uart_transmit if uart_tx is latched, pulse q_instr_done, and update the PC.
  - PC update: q_pc <= r_br ? r_res : q_pc+1. The increment wraps modulo 2^16 (16'hFFFF -> 16'h0000).
  - Next state: HOLD if i_mode=1, else FETCH if i_en=1, else IDLE.
- HOLD: waits for an i_step rising edge, then -> FETCH. An i_mode change to 0 also leaves HOLD -> FETCH. i_en=0 -> IDLE.

Other rules:
- Clearing i_en mid-instruction does not abort; the instruction completes and the block goes to IDLE.
- q_mem_addr=q_pc in every state except MEM.
- q_ce_* and q_mem_we are single-cycle pulses.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, q_pc=RESET_PC, q_mem_addr=RESET_PC.
  - All strobes 0, q_reg_src_mem=0, q_state=0.
  - Internal flags, r_res, r_br and the step-edge register cleared.
- Non-memory instruction: 5+MEM_LAT cycles per instruction (6 at MEM_LAT=1).
- Load/store: 5+2*MEM_LAT cycles per instruction (7 at MEM_LAT=1).
- UART stall adds one cycle per cycle that i_uart_full=1 while in WB.
- FETCH entry to q_ce_dec = MEM_LAT cycles.
- ALU result is valid one cycle after q_ce_alu and is sampled in RES.
- q_pc updates on the clock edge that leaves WB and is visible during the next FETCH.
- Reset deasserted with i_en=1: the first FETCH occurs one cycle later.
- i_step held high: only one step per rising edge.
- Reset asserted mid-MEM: q_mem_we falls immediately and no write-back occurs.

## Test plan
- ALU add, free-run, MEM_LAT=1, PC=5:
  - q_ce_dec/q_ce_reg/q_ce_alu/q_reg_we pulse at cycles 1/2/3/5 relative to FETCH entry.
  - q_instr_done at cycle 5; q_pc=6 afterwards; next FETCH at cycle 6.
- Store, r_res=16'h0040:
  - q_mem_addr=16'h0040 with q_mem_we=1 for exactly one cycle; q_reg_we=0.
  - Load at MEM_LAT=2: q_reg_src_mem=1 in WB; the instruction takes 9 cycles.
- Branch taken, i_alu_result=16'h0100 at RES: next FETCH has q_mem_addr=16'h0100.
  - Separately, PC=16'hFFFF with no branch wraps q_pc to 16'h0000.
- UART push with i_uart_full=1 for 3 cycles:
  - WB lasts 4 cycles; q_uart_transmit pulses once after i_uart_full falls; q_instr_done pulses once.
- Debug mode (i_mode=1): after q_instr_done, state=8 indefinitely.
  - One i_step pulse runs exactly one instruction.
  - i_step held high for 20 cycles runs only one instruction.
- i_reset_n low in MEM (store) or DECODE:
  - All outputs are at reset values in the same cycle, with no q_mem_we.
  - Release with i_en=1 restarts FETCH at RESET_PC.
  - i_en cleared in EXEC: the instruction retires, then q_state=0.
